player_ctrl: RTL and testbench
==============================

Name: player_ctrl

Overview:
- Parametrised per-player controller, one instance per player.
- Moves a rectangular sprite from keyboard keycodes, blocks motion against NUM_WALLS walls and the screen edges, and detects bomb-blast overlap.
- Tracks lives with post-hit invulnerability and rate-limits bomb drops.
- Sits between the keycode decoder and the sprite/bomb/HUD logic.

Parameters:
- NUM_WALLS, 4, number of wall rectangles checked.
- X_START, 20, respawn/reset X.
- Y_START, 20, respawn/reset Y.
- X_SIZE, 16, sprite width in px.
- Y_SIZE, 25, sprite height in px.
- STEP, 1, px moved per frame while a direction key is held.
- X_MAX, 639, rightmost screen px.
- Y_MAX, 479, bottom screen px.
- KEY_UP / KEY_DOWN / KEY_LEFT / KEY_RIGHT / KEY_BOMB, 8'h1A / 8'h16 / 8'h04 / 8'h07 / 8'h19, control keycodes.
- LIVES, 3, starting hearts (1..7).
- INVULN_FRAMES, 120, invulnerable frames after a hit.
- BOMB_COOLDOWN, 180, frames between permitted drops.

Ports:
- frame_clk  in  1  frame-rate clock; all state updates on its rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- keycode  in  8  current keycode; 0 means no key.
- wallX  in  10*NUM_WALLS  packed wall left edges; wall i at [10i+9:10i].
- wallY  in  10*NUM_WALLS  packed wall top edges.
- wallS  in  10*NUM_WALLS  packed wall side lengths (square walls).
- bombX, bombY, bombS  in  10 each  enemy blast square.
- bomb_active  in  1  blast square is live.
- userX, userY  out  10 each  registered sprite top-left.
- heart  out  3  remaining lives.
- bomb_drop  out  1  one-cycle drop pulse.
- damage  out  1  one-cycle pulse on the frame a hit is taken.
- collide  out  1  level: sprite overlaps a live blast this frame, regardless of state.
- invuln  out  1  high while in INVULN.
- dead  out  1  high in DEAD.

Behaviour:
- Reset (Reset_n=0 at an edge), overriding any state including mid-invulnerability or mid-cooldown:
  - userX=X_START, userY=Y_START, heart=LIVES.
  - state=ALIVE; invuln, dead, bomb_drop, damage, collide all 0.
  - Cooldown and invulnerability counters 0; stored previous keycode 0.
- Direction: decoded only from the current keycode; no momentum. No direction key means no move.
- Candidate position = current ± STEP on one axis. Compute in 11 bits.
- Clamp X to [0, X_MAX+1-X_SIZE] and Y to [0, Y_MAX+1-Y_SIZE]. Moving left/up at 0 stays at 0; no wrap-around.
- Overlap test, strict AABB: A overlaps B iff Ax < Bx+Bs && Ax+Aw > Bx && Ay < By+Bs && Ay+Ah > By. All terms 11-bit.
  - Touching edges do not overlap.
- Wall blocking:
  - If the clamped candidate overlaps any wall, position is unchanged this frame. There is no snapping or pushback.
  - A wall with wallS=0 never blocks.
- collide = registered AABB overlap of the current position with the blast && bomb_active.
- State machine:
  - ALIVE:
    - If the current position overlaps a live blast: damage=1 for one cycle, heart-=1, position=(X_START,Y_START), movement suppressed that frame.
    - If heart was 1: heart=0, go to DEAD.
    - Otherwise: load the invulnerability counter with INVULN_FRAMES, go to INVULN.
  - INVULN:
    - Movement and bombs allowed; overlap ignored.
    - Counter decrements each frame. On the frame it reads 1 it reaches 0 and the state returns to ALIVE.
    - invuln=1 for exactly INVULN_FRAMES cycles.
  - DEAD:
    - Position frozen; bomb_drop never asserted; heart=0.
    - Only reset exits.
- Bomb drop:
  - Condition: keycode==KEY_BOMB, previous keycode!=KEY_BOMB (rising edge of the key), cooldown==0, state!=DEAD.
  - Result: bomb_drop=1 for exactly one cycle and cooldown loaded with BOMB_COOLDOWN.
  - Cooldown decrements to 0 and saturates there.
  - Holding the key never re-fires; a press during cooldown is discarded, not queued.
- Simultaneous events:
  - A hit in the same frame as a bomb edge: the hit is processed and no bomb is dropped.
  - A hit in the same frame as a direction key: the respawn wins.
- Latency: every output is registered. A keycode sampled at edge n is reflected on userX/userY/bomb_drop after edge n.

Test Plan:
- Reset_n=0 for 2 cycles, then keycode=KEY_RIGHT for 10 frames -> userX=30, userY=20, heart=3, all pulses 0.
- Wall0 at (40,15,S=20); start (20,20), hold KEY_RIGHT -> userX stops at 24 (24+16=40, touching, no overlap); userX stays 24 for 5 further frames.
- Blast at (20,20,S=30), bomb_active=1, ALIVE:
  - damage pulses 1 cycle, heart=2, position returns to (20,20), invuln=1 for 120 frames.
  - collide stays 1 throughout, damage stays 0.
  - Hit again after invuln falls -> heart=1.
- With heart=1, take a hit -> heart=0, dead=1; KEY_RIGHT and KEY_BOMB have no effect; Reset_n=0 -> heart=3, dead=0.
- Hold KEY_BOMB 400 frames -> exactly 1 pulse. Release, press at frame 100 -> no pulse. Release, press again at frame 200 -> pulse.
- userX=0, hold KEY_LEFT -> userX stays 0. Position 614, hold KEY_RIGHT -> clamps at 624 (639+1-16).

Source files
------------

// File: rtl/player_ctrl.sv
// player_ctrl: per-player controller. Moves a rectangular sprite from keyboard keycodes,
// blocks motion against square walls and the screen edges, detects enemy blast overlap,
// tracks lives with post-hit invulnerability and rate-limits bomb drops.
//
// Ports:
//   frame_clk    frame-rate clock, all state updates on its rising edge
//   Reset_n      synchronous active-low reset
//   keycode      current keycode, 0 = no key
//   wallX/Y/S    packed wall left/top/side, wall i at [10i+9:10i]; side 0 disables the wall
//   bombX/Y/S    enemy blast square, bomb_active marks it live
//   userX/userY  registered sprite top-left
//   heart        remaining lives
//   bomb_drop    one-cycle bomb drop pulse
//   damage       one-cycle pulse on the frame a hit is taken
//   collide      sprite overlapped a live blast on the last frame, regardless of state
//   invuln       high while invulnerable
//   dead         high once all lives are gone
module player_ctrl #(
    parameter int unsigned NUM_WALLS     = 4,
    parameter int unsigned X_START       = 20,
    parameter int unsigned Y_START       = 20,
    parameter int unsigned X_SIZE        = 16,
    parameter int unsigned Y_SIZE        = 25,
    parameter int unsigned STEP          = 1,
    parameter int unsigned X_MAX         = 639,
    parameter int unsigned Y_MAX         = 479,
    parameter logic [7:0]  KEY_UP        = 8'h1A,
    parameter logic [7:0]  KEY_DOWN      = 8'h16,
    parameter logic [7:0]  KEY_LEFT      = 8'h04,
    parameter logic [7:0]  KEY_RIGHT     = 8'h07,
    parameter logic [7:0]  KEY_BOMB      = 8'h19,
    parameter int unsigned LIVES         = 3,
    parameter int unsigned INVULN_FRAMES = 120,
    parameter int unsigned BOMB_COOLDOWN = 180
) (
    input  logic                      frame_clk,
    input  logic                      Reset_n,
    input  logic [7:0]                keycode,
    input  logic [10*NUM_WALLS-1:0]   wallX,
    input  logic [10*NUM_WALLS-1:0]   wallY,
    input  logic [10*NUM_WALLS-1:0]   wallS,
    input  logic [9:0]                bombX,
    input  logic [9:0]                bombY,
    input  logic [9:0]                bombS,
    input  logic                      bomb_active,
    output logic [9:0]                userX,
    output logic [9:0]                userY,
    output logic [2:0]                heart,
    output logic                      bomb_drop,
    output logic                      damage,
    output logic                      collide,
    output logic                      invuln,
    output logic                      dead
);

    localparam logic [1:0] StAlive  = 2'd0;
    localparam logic [1:0] StInvuln = 2'd1;
    localparam logic [1:0] StDead   = 2'd2;

    localparam int unsigned InvW  = $clog2(INVULN_FRAMES + 1);
    localparam int unsigned CoolW = $clog2(BOMB_COOLDOWN + 1);

    localparam logic [10:0] XLim   = 11'(X_MAX + 1 - X_SIZE);
    localparam logic [10:0] YLim   = 11'(Y_MAX + 1 - Y_SIZE);
    localparam logic [10:0] Step   = 11'(STEP);
    localparam logic [10:0] XSz    = 11'(X_SIZE);
    localparam logic [10:0] YSz    = 11'(Y_SIZE);
    localparam logic [9:0]  XStart = 10'(X_START);
    localparam logic [9:0]  YStart = 10'(Y_START);

    // Strict AABB: touching edges do not overlap.
    function automatic logic overlap(input logic [10:0] ax, input logic [10:0] ay,
                                     input logic [10:0] aw, input logic [10:0] ah,
                                     input logic [10:0] bx, input logic [10:0] by,
                                     input logic [10:0] bw, input logic [10:0] bh);
        return (ax < bx + bw) && (ax + aw > bx) && (ay < by + bh) && (ay + ah > by);
    endfunction

    logic [9:0]       x_q, x_d, y_q, y_d;
    logic [2:0]       heart_q, heart_d;
    logic [1:0]       state_q, state_d;
    logic [InvW-1:0]  inv_cnt_q, inv_cnt_d;
    logic [CoolW-1:0] cool_q, cool_d;
    logic [7:0]       prev_key_q;
    logic             drop_q, drop_d;
    logic             damage_q, damage_d;
    logic             collide_q, collide_d;

    logic [10:0] cur_x, cur_y;
    logic [10:0] sum_x, sum_y;
    logic [9:0]  cand_x, cand_y;
    logic [9:0]  move_x, move_y;
    logic        wall_block;
    logic        blast_hit;
    logic        hit_now;
    logic        bomb_fire;

    assign cur_x = {1'b0, x_q};
    assign cur_y = {1'b0, y_q};
    assign sum_x = cur_x + Step;
    assign sum_y = cur_y + Step;

    // Candidate position from the current key only, clamped to the screen.
    always_comb begin
        cand_x = x_q;
        cand_y = y_q;
        case (keycode)
            KEY_UP:    cand_y = (cur_y >= Step) ? 10'(cur_y - Step) : 10'd0;
            KEY_DOWN:  cand_y = (sum_y > YLim) ? 10'(YLim) : 10'(sum_y);
            KEY_LEFT:  cand_x = (cur_x >= Step) ? 10'(cur_x - Step) : 10'd0;
            KEY_RIGHT: cand_x = (sum_x > XLim) ? 10'(XLim) : 10'(sum_x);
            default:   ;
        endcase
    end

    // Any enabled wall overlapping the candidate cancels the whole move.
    always_comb begin
        wall_block = 1'b0;
        for (int i = 0; i < int'(NUM_WALLS); i++) begin
            if (wallS[10*i +: 10] != 10'd0 &&
                overlap({1'b0, cand_x}, {1'b0, cand_y}, XSz, YSz,
                        {1'b0, wallX[10*i +: 10]}, {1'b0, wallY[10*i +: 10]},
                        {1'b0, wallS[10*i +: 10]}, {1'b0, wallS[10*i +: 10]})) begin
                wall_block = 1'b1;
            end
        end
        move_x = wall_block ? x_q : cand_x;
        move_y = wall_block ? y_q : cand_y;
    end

    assign blast_hit = bomb_active &&
                       overlap(cur_x, cur_y, XSz, YSz, {1'b0, bombX}, {1'b0, bombY},
                               {1'b0, bombS}, {1'b0, bombS});
    assign hit_now   = (state_q == StAlive) && blast_hit;
    // A hit in the same frame swallows the bomb press.
    assign bomb_fire = (keycode == KEY_BOMB) && (prev_key_q != KEY_BOMB) &&
                       (cool_q == '0) && (state_q != StDead) && !hit_now;

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        heart_d   = heart_q;
        state_d   = state_q;
        inv_cnt_d = inv_cnt_q;
        cool_d    = (cool_q != '0) ? cool_q - CoolW'(1) : '0;
        drop_d    = 1'b0;
        damage_d  = 1'b0;
        collide_d = blast_hit;

        case (state_q)
            StAlive: begin
                if (blast_hit) begin
                    damage_d = 1'b1;
                    heart_d  = heart_q - 3'd1;
                    x_d      = XStart;
                    y_d      = YStart;
                    if (heart_q == 3'd1) begin
                        state_d = StDead;
                    end else begin
                        inv_cnt_d = InvW'(INVULN_FRAMES);
                        state_d   = StInvuln;
                    end
                end else begin
                    x_d = move_x;
                    y_d = move_y;
                end
            end
            StInvuln: begin
                x_d = move_x;
                y_d = move_y;
                if (inv_cnt_q <= InvW'(1)) begin
                    inv_cnt_d = '0;
                    state_d   = StAlive;
                end else begin
                    inv_cnt_d = inv_cnt_q - InvW'(1);
                end
            end
            StDead: begin
                heart_d = 3'd0;
            end
            default: begin
                state_d = StAlive;
            end
        endcase

        if (bomb_fire) begin
            drop_d = 1'b1;
            cool_d = CoolW'(BOMB_COOLDOWN);
        end
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            x_q        <= XStart;
            y_q        <= YStart;
            heart_q    <= 3'(LIVES);
            state_q    <= StAlive;
            inv_cnt_q  <= '0;
            cool_q     <= '0;
            prev_key_q <= 8'd0;
            drop_q     <= 1'b0;
            damage_q   <= 1'b0;
            collide_q  <= 1'b0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            heart_q    <= heart_d;
            state_q    <= state_d;
            inv_cnt_q  <= inv_cnt_d;
            cool_q     <= cool_d;
            prev_key_q <= keycode;
            drop_q     <= drop_d;
            damage_q   <= damage_d;
            collide_q  <= collide_d;
        end
    end

    assign userX     = x_q;
    assign userY     = y_q;
    assign heart     = heart_q;
    assign bomb_drop = drop_q;
    assign damage    = damage_q;
    assign collide   = collide_q;
    assign invuln    = (state_q == StInvuln);
    assign dead      = (state_q == StDead);

endmodule

// File: tb/tb_player_ctrl.sv
// Scoreboard bench for player_ctrl: the stimulus process pushes the expected outputs for
// each frame, a monitor pops one entry per frame just after the clock edge and compares.
module tb_player_ctrl;

    localparam logic [7:0] KUp    = 8'h1A;
    localparam logic [7:0] KDown  = 8'h16;
    localparam logic [7:0] KLeft  = 8'h04;
    localparam logic [7:0] KRight = 8'h07;
    localparam logic [7:0] KBomb  = 8'h19;
    localparam logic [6:0] MAll   = 7'h7F;
    localparam logic [6:0] MPos   = 7'h01;

    logic        frame_clk = 1'b0;
    logic        Reset_n   = 1'b0;
    logic [7:0]  keycode   = 8'd0;
    logic [39:0] wallX     = '0;
    logic [39:0] wallY     = '0;
    logic [39:0] wallS     = '0;
    logic [9:0]  bombX     = '0;
    logic [9:0]  bombY     = '0;
    logic [9:0]  bombS     = '0;
    logic        bomb_active = 1'b0;
    logic [9:0]  userX, userY;
    logic [2:0]  heart;
    logic        bomb_drop, damage, collide, invuln, dead;

    // Input values applied at the next frame boundary.
    logic [39:0] nw_x = '0, nw_y = '0, nw_s = '0;
    logic [9:0]  nb_x = '0, nb_y = '0, nb_s = '0;
    logic        nb_act = 1'b0;

    typedef struct {
        string      name;
        logic [6:0] mask;  // pos, heart, drop, damage, collide, invuln, dead
        int         x, y, hrt;
        bit         drop, dmg, col, inv, dd;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    player_ctrl dut (
        .frame_clk   (frame_clk),
        .Reset_n     (Reset_n),
        .keycode     (keycode),
        .wallX       (wallX),
        .wallY       (wallY),
        .wallS       (wallS),
        .bombX       (bombX),
        .bombY       (bombY),
        .bombS       (bombS),
        .bomb_active (bomb_active),
        .userX       (userX),
        .userY       (userY),
        .heart       (heart),
        .bomb_drop   (bomb_drop),
        .damage      (damage),
        .collide     (collide),
        .invuln      (invuln),
        .dead        (dead)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: one expected entry per frame, sampled 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge frame_clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.mask[0]) begin
                    chk({e.name, ".userX"}, 32'(userX), 32'(e.x));
                    chk({e.name, ".userY"}, 32'(userY), 32'(e.y));
                end
                if (e.mask[1]) chk({e.name, ".heart"},     32'(heart),     32'(e.hrt));
                if (e.mask[2]) chk({e.name, ".bomb_drop"}, 32'(bomb_drop), 32'(e.drop));
                if (e.mask[3]) chk({e.name, ".damage"},    32'(damage),    32'(e.dmg));
                if (e.mask[4]) chk({e.name, ".collide"},   32'(collide),   32'(e.col));
                if (e.mask[5]) chk({e.name, ".invuln"},    32'(invuln),    32'(e.inv));
                if (e.mask[6]) chk({e.name, ".dead"},      32'(dead),      32'(e.dd));
            end
        end
    end

    task automatic apply_inputs(input logic rst_n, input logic [7:0] k);
        Reset_n     = rst_n;
        keycode     = k;
        wallX       = nw_x;
        wallY       = nw_y;
        wallS       = nw_s;
        bombX       = nb_x;
        bombY       = nb_y;
        bombS       = nb_s;
        bomb_active = nb_act;
    endtask

    task automatic frame(input logic [7:0] k, input string nm, input logic [6:0] m,
                         input int ex, input int ey, input int eh, input bit edrop,
                         input bit edmg, input bit ecol, input bit einv, input bit edead);
        exp_t e;
        @(negedge frame_clk);
        apply_inputs(1'b1, k);
        e.name = nm; e.mask = m; e.x = ex; e.y = ey; e.hrt = eh;
        e.drop = edrop; e.dmg = edmg; e.col = ecol; e.inv = einv; e.dd = edead;
        sb.push_back(e);
    endtask

    task automatic reset_frames(input int n, input string nm);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge frame_clk);
            apply_inputs(1'b0, 8'd0);
            e.name = nm; e.mask = MAll; e.x = 20; e.y = 20; e.hrt = 3;
            e.drop = 0; e.dmg = 0; e.col = 0; e.inv = 0; e.dd = 0;
            sb.push_back(e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, then walk right ten frames.
        reset_frames(2, "reset");
        for (int i = 1; i <= 10; i++)
            frame(KRight, "walk_right", MAll, 20 + i, 20, 3, 0, 0, 0, 0, 0);

        // Wall at (40,15,20): stops at 24 where edges touch.
        reset_frames(2, "reset_wall");
        nw_x[9:0] = 10'd40; nw_y[9:0] = 10'd15; nw_s[9:0] = 10'd20;
        for (int i = 1; i <= 9; i++)
            frame(KRight, "wall_block", MAll, (i < 4) ? 20 + i : 24, 20, 3, 0, 0, 0, 0, 0);
        nw_x = '0; nw_y = '0; nw_s = '0;

        // Blast over the spawn point: hit, invulnerability, re-hit, death.
        reset_frames(2, "reset_blast");
        nb_x = 10'd20; nb_y = 10'd20; nb_s = 10'd30; nb_act = 1'b1;
        frame(KRight, "hit1_respawn_wins", MAll, 20, 20, 2, 0, 1, 1, 1, 0);
        for (int i = 2; i <= 120; i++)
            frame(8'd0, "invuln1", MAll, 20, 20, 2, 0, 0, 1, 1, 0);
        frame(8'd0, "invuln1_end", MAll, 20, 20, 2, 0, 0, 1, 0, 0);
        frame(KBomb, "hit2_no_bomb", MAll, 20, 20, 1, 0, 1, 1, 1, 0);
        for (int i = 123; i <= 241; i++)
            frame(8'd0, "invuln2", MAll, 20, 20, 1, 0, 0, 1, 1, 0);
        frame(8'd0, "invuln2_end", MAll, 20, 20, 1, 0, 0, 1, 0, 0);
        frame(8'd0, "hit3_dead", MAll, 20, 20, 0, 0, 1, 1, 0, 1);
        nb_act = 1'b0;
        for (int i = 0; i < 3; i++)
            frame(KRight, "dead_frozen", MAll, 20, 20, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++)
            frame(KBomb, "dead_no_bomb", MAll, 20, 20, 0, 0, 0, 0, 0, 1);
        reset_frames(2, "reset_from_dead");

        // Bomb: held key fires once; cooldown discards presses; first legal frame fires.
        frame(KBomb, "bomb_first", MAll, 20, 20, 3, 1, 0, 0, 0, 0);
        for (int i = 2; i <= 400; i++)
            frame(KBomb, "bomb_hold", MAll, 20, 20, 3, 0, 0, 0, 0, 0);
        frame(8'd0, "bomb_release", MAll, 20, 20, 3, 0, 0, 0, 0, 0);
        frame(KBomb, "bomb_second", MAll, 20, 20, 3, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 99; i++)
            frame(8'd0, "bomb_idle", MAll, 20, 20, 3, 0, 0, 0, 0, 0);
        frame(KBomb, "bomb_in_cooldown", MAll, 20, 20, 3, 0, 0, 0, 0, 0);
        for (int i = 101; i <= 199; i++)
            frame(8'd0, "bomb_idle", MAll, 20, 20, 3, 0, 0, 0, 0, 0);
        frame(KBomb, "bomb_after_cooldown", MAll, 20, 20, 3, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 180; i++)
            frame(8'd0, "bomb_idle", MAll, 20, 20, 3, 0, 0, 0, 0, 0);
        frame(KBomb, "bomb_cooldown_edge", MAll, 20, 20, 3, 1, 0, 0, 0, 0);

        // Screen-edge clamps on both axes.
        reset_frames(2, "reset_edges");
        for (int i = 1; i <= 25; i++)
            frame(KLeft, "left_clamp", MPos, (i < 20) ? 20 - i : 0, 20, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 630; i++)
            frame(KRight, "right_clamp", MPos, (i < 624) ? i : 624, 20, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 25; i++)
            frame(KUp, "up_clamp", MPos, 624, (i < 20) ? 20 - i : 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 460; i++)
            frame(KDown, "down_clamp", MPos, 624, (i < 455) ? i : 455, 0, 0, 0, 0, 0, 0);

        @(negedge frame_clk);
        keycode = 8'd0;
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge frame_clk);
        #2;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
